// File: rtl/sequential_divider_pkg.sv
// Shared definitions for the restoring sequential divider: state encoding
// and the iteration counter width helper.
package sequential_divider_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIVIDE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Counter must hold WORD_LENGTH-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/sequential_divider_div_step.sv
// One restoring-division iteration: trial subtract of the divisor from the
// shifted partial remainder, keeping the difference only when non-negative.
module div_step #(
  parameter int WORD_LENGTH = 8
) (
  input  logic [WORD_LENGTH:0]   rem_shifted,
  input  logic [WORD_LENGTH-1:0] divisor,
  output logic [WORD_LENGTH-1:0] rem_next,
  output logic                   q_bit
);

  logic [WORD_LENGTH:0] trial;

  // When the trial goes negative the shifted remainder is below the divisor,
  // so its top bit is zero and the low WORD_LENGTH bits lose nothing.
  assign trial    = rem_shifted - {1'b0, divisor};
  assign q_bit    = ~trial[WORD_LENGTH];
  assign rem_next = q_bit ? trial[WORD_LENGTH-1:0] : rem_shifted[WORD_LENGTH-1:0];

endmodule

// File: rtl/sequential_divider.sv
// Restoring shift-and-subtract unsigned divider, one quotient bit per clock.
// Results hold from the done pulse until the next accepted start.
module sequential_divider
  import sequential_divider_pkg::*;
#(
  parameter int WORD_LENGTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WORD_LENGTH-1:0] dividend,
  input  logic [WORD_LENGTH-1:0] divisor,
  output logic [WORD_LENGTH-1:0] quotient,
  output logic [WORD_LENGTH-1:0] remainder,
  output logic                   busy,
  output logic                   done,
  output logic                   div_by_zero
);

  localparam int CW = cnt_width(WORD_LENGTH);

  logic [1:0]             state;
  logic [WORD_LENGTH-1:0] rem_r;
  logic [WORD_LENGTH-1:0] quo_r;
  logic [WORD_LENGTH-1:0] div_r;
  logic [CW-1:0]          count;
  logic                   dbz_r;
  logic [WORD_LENGTH:0]   rem_shifted;
  logic [WORD_LENGTH-1:0] rem_next;
  logic                   q_bit;

  // The partial remainder never exceeds the divisor, so its stored width is
  // WORD_LENGTH; the extra bit only exists in the shifted trial value.
  assign rem_shifted = {rem_r, quo_r[WORD_LENGTH-1]};

  div_step #(.WORD_LENGTH(WORD_LENGTH)) u_step (
    .rem_shifted (rem_shifted),
    .divisor     (div_r),
    .rem_next    (rem_next),
    .q_bit       (q_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      rem_r <= '0;
      quo_r <= '0;
      div_r <= '0;
      count <= '0;
      dbz_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            div_r <= divisor;
            if (divisor == '0) begin
              quo_r <= '1;
              rem_r <= dividend;
              dbz_r <= 1'b1;
              state <= ST_DONE;
            end else begin
              quo_r <= dividend;
              rem_r <= '0;
              count <= CW'(WORD_LENGTH - 1);
              dbz_r <= 1'b0;
              state <= ST_DIVIDE;
            end
          end
        end
        ST_DIVIDE: begin
          rem_r <= rem_next;
          quo_r <= {quo_r[WORD_LENGTH-2:0], q_bit};
          count <= count - CW'(1);
          if (count == '0) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign quotient    = quo_r;
  assign remainder   = rem_r;
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_sequential_divider.sv
// Scoreboard bench for sequential_divider at WORD_LENGTH 8 and 16: stimulus
// pushes arithmetic expectations, monitors pop them on every done pulse.
module tb_sequential_divider;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start8, busy8, done8, dbz8;
  logic [7:0]  dvd8, dvs8, quo8, rem8;
  logic        start16, busy16, done16, dbz16;
  logic [15:0] dvd16, dvs16, quo16, rem16;

  int compared = 0;
  int mismatched = 0;
  int acc8 = 0, acc16 = 0, dcnt8 = 0, dcnt16 = 0;
  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;

  sequential_divider #(.WORD_LENGTH(8)) u_div8 (
    .clk(clk), .reset(reset), .start(start8), .dividend(dvd8), .divisor(dvs8),
    .quotient(quo8), .remainder(rem8), .busy(busy8), .done(done8),
    .div_by_zero(dbz8)
  );

  sequential_divider #(.WORD_LENGTH(16)) u_div16 (
    .clk(clk), .reset(reset), .start(start16), .dividend(dvd16), .divisor(dvs16),
    .quotient(quo16), .remainder(rem16), .busy(busy16), .done(done16),
    .div_by_zero(dbz16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division, with the all-ones / dividend rule for zero.
  function automatic exp_t mk(input logic [15:0] a, input logic [15:0] b, input int w);
    exp_t e;
    logic [15:0] mask;
    mask = 16'((32'd1 << w) - 1);
    e.a = a;
    e.b = b;
    e.z = (b == 16'd0);
    e.q = e.z ? mask : a / b;
    e.r = e.z ? a : a % b;
    return e;
  endfunction

  always @(negedge clk) begin
    if (done8 && !reset) begin
      dcnt8++;
      if (q8.size() == 0) chk("done8_unexpected", 32'd1, 32'd0);
      else begin
        e8 = q8.pop_front();
        chk("quo8", quo8, e8.q);
        chk("rem8", rem8, e8.r);
        chk("dbz8", dbz8, e8.z);
        if (!e8.z) chk("inv8", quo8 * e8.b + rem8, e8.a);
      end
    end
  end

  always @(negedge clk) begin
    if (done16 && !reset) begin
      dcnt16++;
      if (q16.size() == 0) chk("done16_unexpected", 32'd1, 32'd0);
      else begin
        e16 = q16.pop_front();
        chk("quo16", quo16, e16.q);
        chk("rem16", rem16, e16.r);
        chk("dbz16", dbz16, e16.z);
        if (!e16.z) chk("inv16", quo16 * e16.b + rem16, e16.a);
      end
    end
  end

  // Issues one operation and returns cycles from the accepting edge to done.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, output int lat);
    int guard = 0;
    @(negedge clk);
    while (busy8 && guard < 100) begin @(negedge clk); guard++; end
    start8 = 1'b1; dvd8 = a; dvs8 = b;
    q8.push_back(mk(a, b, 8)); acc8++;
    @(negedge clk);
    start8 = 1'b0; dvd8 = 8'($urandom); dvs8 = 8'($urandom);
    lat = 1;
    while (!done8 && lat < 100) begin @(negedge clk); lat++; end
    if (lat >= 100) chk("timeout8", 32'd1, 32'd0);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, output int lat);
    int guard = 0;
    @(negedge clk);
    while (busy16 && guard < 100) begin @(negedge clk); guard++; end
    start16 = 1'b1; dvd16 = a; dvs16 = b;
    q16.push_back(mk(a, b, 16)); acc16++;
    @(negedge clk);
    start16 = 1'b0; dvd16 = 16'($urandom); dvs16 = 16'($urandom);
    lat = 1;
    while (!done16 && lat < 100) begin @(negedge clk); lat++; end
    if (lat >= 100) chk("timeout16", 32'd1, 32'd0);
  endtask

  initial begin
    int lat, guard, n, t1, t2;
    logic [15:0] a, b;
    reset = 1'b1; start8 = 0; start16 = 0;
    dvd8 = 0; dvs8 = 0; dvd16 = 0; dvs16 = 0;
    repeat (2) @(negedge clk);
    chk("rst_quo", quo8, 0);
    chk("rst_rem", rem8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_dbz", dbz8, 0);
    reset = 1'b0;

    op8(8'd100, 8'd7, lat);  chk("lat_100_7", lat, 9);
    chk("busy_at_done", busy8, 1);
    @(negedge clk); chk("busy_after_done", busy8, 0);
    chk("hold_quo", quo8, 14);
    op8(8'd255, 8'd1, lat);  chk("lat_255_1", lat, 9);
    op8(8'd5, 8'd9, lat);
    op8(8'd255, 8'd255, lat);
    op8(8'd42, 8'd0, lat);   chk("lat_dbz", lat, 1);
    op8(8'd10, 8'd3, lat);   chk("lat_10_3", lat, 9);

    // Start re-asserted while busy must be ignored.
    @(negedge clk);
    start8 = 1'b1; dvd8 = 8'd200; dvs8 = 8'd13;
    q8.push_back(mk(16'd200, 16'd13, 8)); acc8++;
    @(negedge clk); start8 = 1'b0;
    repeat (2) @(negedge clk);
    start8 = 1'b1; dvd8 = 8'd9; dvs8 = 8'd2;
    @(negedge clk); start8 = 1'b0;
    repeat (16) @(negedge clk);

    // Asynchronous reset between edges mid-division.
    start8 = 1'b1; dvd8 = 8'd123; dvs8 = 8'd4;
    @(negedge clk); start8 = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_quo", quo8, 0);
    chk("mid_rst_rem", rem8, 0);
    chk("mid_rst_busy", busy8, 0);
    chk("mid_rst_done", done8, 0);
    @(negedge clk); reset = 1'b0;
    op8(8'd77, 8'd8, lat);   chk("lat_77_8", lat, 9);

    // Start held high: back-to-back ops, one IDLE cycle between.
    @(negedge clk);
    start8 = 1'b1; dvd8 = 8'd50; dvs8 = 8'd6;
    for (int i = 0; i < 3; i++) begin q8.push_back(mk(16'd50, 16'd6, 8)); acc8++; end
    n = 0; guard = 0; t1 = 0; t2 = 0;
    while (n < 3 && guard < 100) begin
      @(negedge clk); guard++;
      if (done8) begin n++; if (n == 1) t1 = guard; if (n == 2) t2 = guard; end
    end
    start8 = 1'b0;
    chk("b2b_count", n, 3);
    chk("b2b_gap", t2 - t1, 10);

    for (int i = 0; i < 60; i++) begin
      a = 16'($urandom_range(0, 255));
      b = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 255));
      op8(a[7:0], b[7:0], lat);
      chk("lat8_rand", lat, (b == 0) ? 1 : 9);
    end

    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
      if (i == 0) begin a = 16'hFFFF; b = 16'd1; end
      if (i == 1) begin a = 16'd3; b = 16'hFFFF; end
      op16(a, b, lat);
      chk("lat16_rand", lat, (b == 0) ? 1 : 17);
    end

    repeat (4) @(negedge clk);
    chk("done_count8", dcnt8, acc8);
    chk("done_count16", dcnt16, acc16);
    chk("q8_empty", q8.size(), 0);
    chk("q16_empty", q16.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
